// File: rtl/vga_scanout.sv
// vga_scanout: double-buffered frame buffer with VGA timing and scan-out.
// A write port fills the back bank; a swap request flips banks at the start
// of the vertical front porch so the visible image never tears.
module vga_scanout #(
    parameter int H_SYNC_CYC   = 96,
    parameter int H_SYNC_BACK  = 48,
    parameter int H_SYNC_ACT   = 640,
    parameter int H_SYNC_FRONT = 16,
    parameter int V_SYNC_CYC   = 2,
    parameter int V_SYNC_BACK  = 33,
    parameter int V_SYNC_ACT   = 480,
    parameter int V_SYNC_FRONT = 10,
    parameter int FB_W         = 256,
    parameter int FB_H         = 256,
    parameter int SCALE        = 1,
    parameter int CW           = 8,
    parameter int OW           = 10,
    parameter int CLK_DIV      = 2,
    parameter int X_OFF        = 192,
    parameter int Y_OFF        = 112
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    write,
    input  logic [$clog2(FB_W)-1:0] x_write,
    input  logic [$clog2(FB_H)-1:0] y_write,
    input  logic [CW-1:0]           r,
    input  logic [CW-1:0]           g,
    input  logic [CW-1:0]           b,
    input  logic                    display,
    output logic                    busy,
    output logic [OW-1:0]           vga_r,
    output logic [OW-1:0]           vga_g,
    output logic [OW-1:0]           vga_b,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    vga_blank_n,
    output logic                    vga_sync_n,
    output logic                    frame_start
);
    localparam int H_TOTAL = H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT + H_SYNC_FRONT;
    localparam int V_TOTAL = V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT + V_SYNC_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(FB_W);
    localparam int YW      = $clog2(FB_H);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW      = 3 * CW;
    localparam int H_ACT0  = H_SYNC_CYC + H_SYNC_BACK;
    localparam int H_ACT1  = H_ACT0 + H_SYNC_ACT;
    localparam int V_ACT0  = V_SYNC_CYC + V_SYNC_BACK;
    localparam int V_ACT1  = V_ACT0 + V_SYNC_ACT;   // first front-porch line
    localparam int X_WIN0  = H_ACT0 + X_OFF;
    localparam int X_WIN1  = X_WIN0 + FB_W * SCALE;
    localparam int Y_WIN0  = V_ACT0 + Y_OFF;
    localparam int Y_WIN1  = Y_WIN0 + FB_H * SCALE;

    typedef enum logic {IDLE, PENDING} state_t;

    logic [DW-1:0]    div;
    logic             tick;
    logic [HW-1:0]    hcnt;
    logic [VW-1:0]    vcnt;
    int               hc, vc;
    logic             h_act, v_act, in_win;
    logic [XW-1:0]    fx;
    logic [YW-1:0]    fy;
    logic [XW+YW-1:0] s1_addr;
    logic             s1_hs, s1_vs, s1_bn, s1_win, vld_s1;
    logic [PW-1:0]    rd_pix;
    logic             front;
    state_t           state;

    // Both banks in one array; the MSB of the index selects the bank.
    logic [PW-1:0]    mem [0:2*FB_W*FB_H-1];

    // MSB replication widens a colour channel so full scale maps to full scale.
    function automatic logic [OW-1:0] expand(input logic [CW-1:0] c);
        logic [OW-1:0] o;
        o = '0;
        for (int i = 0; i < OW; i++)
            o[OW-1-i] = c[CW-1-(i % CW)];
        return o;
    endfunction

    assign tick = (div == DW'(CLK_DIV - 1));

    // Free-running pixel-clock divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div <= '0;
        else if (tick) div <= '0;
        else           div <= div + 1'b1;
    end

    // Raster counters, advanced once per pixel tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (tick) begin
            if (hcnt == HW'(H_TOTAL - 1)) begin
                hcnt <= '0;
                vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    assign hc     = int'(hcnt);
    assign vc     = int'(vcnt);
    assign h_act  = (hc >= H_ACT0) && (hc < H_ACT1);
    assign v_act  = (vc >= V_ACT0) && (vc < V_ACT1);
    assign in_win = (hc >= X_WIN0) && (hc < X_WIN1) && (vc >= Y_WIN0) && (vc < Y_WIN1);
    assign fx     = XW'((hc - X_WIN0) / SCALE);
    assign fy     = YW'((vc - Y_WIN0) / SCALE);

    // Stage 1: frame-buffer address plus the timing flags that travel with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_addr <= '0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_bn   <= 1'b0;
            s1_win  <= 1'b0;
            vld_s1  <= 1'b0;
        end else if (tick) begin
            s1_addr <= {fy, fx};
            s1_hs   <= (hc >= H_SYNC_CYC);
            s1_vs   <= (vc >= V_SYNC_CYC);
            s1_bn   <= h_act && v_act;
            s1_win  <= h_act && v_act && in_win;
            vld_s1  <= 1'b1;
        end
    end

    assign rd_pix = mem[{front, s1_addr}];

    // Stage 2: RAM read into the output colour register, sync kept aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (tick && vld_s1) begin
            vga_hs      <= s1_hs;
            vga_vs      <= s1_vs;
            vga_blank_n <= s1_bn;
            vga_r       <= s1_win ? expand(rd_pix[3*CW-1 -: CW]) : '0;
            vga_g       <= s1_win ? expand(rd_pix[2*CW-1 -: CW]) : '0;
            vga_b       <= s1_win ? expand(rd_pix[CW-1   -: CW]) : '0;
        end
    end

    assign vga_sync_n = 1'b0;

    // One-clk marker on the tick that starts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_start <= 1'b0;
        else        frame_start <= tick && (hcnt == '0) && (vcnt == '0);
    end

    // Back-bank write port; RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (write && !busy)
            mem[{~front, y_write, x_write}] <= {r, g, b};
    end

    // Swap FSM: latch a request, flip banks at front-porch entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            front <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (display) begin
                        state <= PENDING;
                        busy  <= 1'b1;
                    end
                end
                PENDING: begin
                    if (tick && (hcnt == '0) && (vcnt == VW'(V_ACT1))) begin
                        front <= ~front;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster (28x18 ticks, 4x4 buffer, 2x scale).
module tb_vga_scanout;
    localparam int HS = 4, HB = 4, HA = 16, HF = 4;
    localparam int VS = 2, VB = 2, VA = 12, VF = 2;
    localparam int FBW = 4, FBH = 4, SC = 2, CDIV = 2, XO = 3, YO = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       write = 1'b0, display = 1'b0;
    logic [1:0] x_write = '0, y_write = '0;
    logic [7:0] r = '0, g = '0, b = '0;
    logic       busy, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
    logic [9:0] vga_r, vga_g, vga_b;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_SYNC_CYC(HS), .H_SYNC_BACK(HB), .H_SYNC_ACT(HA), .H_SYNC_FRONT(HF),
        .V_SYNC_CYC(VS), .V_SYNC_BACK(VB), .V_SYNC_ACT(VA), .V_SYNC_FRONT(VF),
        .FB_W(FBW), .FB_H(FBH), .SCALE(SC), .CW(8), .OW(10), .CLK_DIV(CDIV),
        .X_OFF(XO), .Y_OFF(YO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .write(write), .x_write(x_write), .y_write(y_write),
        .r(r), .g(g), .b(b), .display(display), .busy(busy),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .frame_start(frame_start)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [9:0] r, g, b;
        logic       hs, vs, bn, known;
    } pix_t;

    logic [23:0] m_mem   [0:1][0:15];
    logic        m_known [0:1][0:15];
    logic        m_front, m_pending, exp_fs;
    int          e_cnt;
    pix_t        exp_p;

    function automatic logic [9:0] exp10(input logic [7:0] c);
        logic [9:0] w;
        w = {2'b00, c};
        return (w << 2) | (w >> 6);
    endfunction

    // What the video outputs must show for linear raster position p.
    function automatic pix_t pix(input int p);
        pix_t o;
        int h, v, ax, ay, idx;
        logic [23:0] c;
        h = p % HT;
        v = p / HT;
        o = '0;
        o.known = 1'b1;
        o.hs = (h >= HS);
        o.vs = (v >= VS);
        if (h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA) begin
            o.bn = 1'b1;
            ax = h - (HS + HB);
            ay = v - (VS + VB);
            if (ax >= XO && ax < XO + FBW * SC && ay >= YO && ay < YO + FBH * SC) begin
                idx = ((ay - YO) / SC) * FBW + (ax - XO) / SC;
                c = m_mem[m_front][idx];
                o.r = exp10(c[23:16]);
                o.g = exp10(c[15:8]);
                o.b = exp10(c[7:0]);
                o.known = m_known[m_front][idx];
            end
        end
        return o;
    endfunction

    function automatic bit is_tick(input int e);
        return (e % CDIV) == 0;
    endfunction

    function automatic int tick_idx(input int e);
        return e / CDIV - 1;
    endfunction

    // Edge-count view of the raster: tick j shows position j-1 on the outputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt     <= 0;
            exp_p     <= {30'd0, 1'b1, 1'b1, 1'b0, 1'b1};
            exp_fs    <= 1'b0;
            m_front   <= 1'b0;
            m_pending <= 1'b0;
        end else begin
            e_cnt  <= e_cnt + 1;
            exp_fs <= 1'b0;
            if (is_tick(e_cnt + 1)) begin
                exp_fs <= (tick_idx(e_cnt + 1) % FT) == 0;
                if (tick_idx(e_cnt + 1) >= 1)
                    exp_p <= pix((tick_idx(e_cnt + 1) - 1) % FT);
            end
            if (m_pending) begin
                if (is_tick(e_cnt + 1) && (tick_idx(e_cnt + 1) % FT) == (VS + VB + VA) * HT) begin
                    m_front   <= !m_front;
                    m_pending <= 1'b0;
                end
            end else if (display) begin
                m_pending <= 1'b1;
            end
            if (write && !m_pending) begin
                m_mem[!m_front][int'(y_write) * FBW + int'(x_write)]   <= {r, g, b};
                m_known[!m_front][int'(y_write) * FBW + int'(x_write)] <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        n_chk++;
        if ({vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, busy} !==
            {exp_p.hs, exp_p.vs, exp_p.bn, 1'b0, exp_fs, m_pending}) begin
            n_fail++;
            $display("FAIL ctl @%0t: got hs/vs/bn/sn/fs/busy=%b%b%b%b%b%b want %b%b%b0%b%b", $time,
                     vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, busy,
                     exp_p.hs, exp_p.vs, exp_p.bn, exp_fs, m_pending);
        end
        if (exp_p.known) begin
            n_chk++;
            if ({vga_r, vga_g, vga_b} !== {exp_p.r, exp_p.g, exp_p.b}) begin
                n_fail++;
                $display("FAIL colour @%0t: got %h %h %h want %h %h %h", $time,
                         vga_r, vga_g, vga_b, exp_p.r, exp_p.g, exp_p.b);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic wr(input int x, input int y, input logic [23:0] c);
        write = 1'b1;
        x_write = 2'(x);
        y_write = 2'(y);
        {r, g, b} = c;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic pulse_display();
        display = 1'b1;
        @(posedge clk); #1;
        display = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_frame();
        int k;
        for (k = 0; k < 1100; k++) begin
            @(posedge clk); #1;
            if (frame_start) break;
        end
        chk("wait_frame_timeout", {31'd0, frame_start}, 32'd1);
    endtask

    initial begin
        int n, hs_lo, vs_lo;
        for (int bk = 0; bk < 2; bk++)
            for (int i = 0; i < 16; i++) begin
                m_known[bk][i] = 1'b0;
                m_mem[bk][i]   = '0;
            end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sync", {26'd0, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, busy}, 32'b110000);
        chk("rst_colour", {2'd0, vga_r, vga_g, vga_b}, 32'd0);

        // First tick lands CLK_DIV clks after release, at raster origin
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_tick_early", {31'd0, frame_start}, 32'd0);
        @(posedge clk); #1;
        chk("first_tick", {31'd0, frame_start}, 32'd1);

        // Fill bank 1, show it; then fill bank 0 and show it
        for (int i = 0; i < 16; i++)
            wr(i % 4, i / 4, {8'(i * 16), 8'(8'hE0 + i), 8'(i * 7 + 1)});
        pulse_display();
        wait_idle();
        for (int i = 0; i < 16; i++)
            wr(i % 4, i / 4, {8'(i * 9 + 3), 8'(255 - i * 5), 8'(i * 13)});
        wr(0, 0, 24'hFF0080);
        wr(3, 0, 24'h123456);
        wr(1, 1, 24'h112233);
        pulse_display();
        wait_idle();

        // One full frame: pixel spot checks, sync widths, frame period
        wait_frame();
        n = 0; hs_lo = 0; vs_lo = 0;
        while (n < 1100) begin
            @(posedge clk); n++; #1;
            if (!vga_hs) hs_lo++;
            if (!vga_vs) vs_lo++;
            case (n)
                358: chk("left_of_window", {1'b0, vga_r, vga_g, vga_b, vga_blank_n}, 32'd1);
                360: chk("pix00",          {2'd0, vga_r, vga_g, vga_b}, {2'd0, 10'h3FF, 10'h000, 10'h202});
                362: chk("pix00_hrep",     {2'd0, vga_r, vga_g, vga_b}, {2'd0, 10'h3FF, 10'h000, 10'h202});
                374: chk("pix30",          {2'd0, vga_r, vga_g, vga_b}, {2'd0, 10'h048, 10'h0D0, 10'h159});
                376: chk("right_of_window",{1'b0, vga_r, vga_g, vga_b, vga_blank_n}, 32'd1);
                416: chk("pix00_vrep",     {2'd0, vga_r, vga_g, vga_b}, {2'd0, 10'h3FF, 10'h000, 10'h202});
                default: ;
            endcase
            if (frame_start) break;
        end
        chk("frame_period", n, 32'd1008);
        chk("hs_low_clks", hs_lo, 32'd144);
        chk("vs_low_clks", vs_lo, 32'd112);

        // Writes while busy are dropped: bank 0 (1,1) keeps 11,22,33
        pulse_display();
        wr(1, 1, 24'hAAAAAA);
        wait_idle();
        pulse_display();
        wait_idle();
        wait_frame();
        repeat (476) @(posedge clk);
        #1;
        chk("pix11_kept", {2'd0, vga_r, vga_g, vga_b}, {2'd0, 10'h044, 10'h088, 10'h0CC});

        // Extra display pulses while pending are ignored; busy drops at porch entry
        wait_frame();
        display = 1'b1;
        @(posedge clk); #1;
        display = 1'b0;
        n = 1;
        while (n < 3000) begin
            @(posedge clk); n++; #1;
            display = (n == 10) || (n == 20);
            if (!busy) break;
        end
        display = 1'b0;
        chk("busy_fall_clks", n, 32'd896);

        // Reset mid-swap cancels it and returns front to bank 0
        pulse_display();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_sync", {28'd0, vga_hs, vga_vs, vga_blank_n, frame_start}, 32'b1100);
        chk("midrst_colour", {2'd0, vga_r, vga_g, vga_b}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_frame();
        repeat (360) @(posedge clk);
        #1;
        chk("front0_after_rst", {2'd0, vga_r, vga_g, vga_b}, {2'd0, 10'h3FF, 10'h000, 10'h202});
        repeat (700) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
